seg_ring_monitor: RTL and testbench

Receive-side checker for the seven-segment ring display. Samples the 8-bit segment bus once per `sample_en` strobe and decodes the pattern back to a digit. Tracks the one-hot ring sequence 1→2→4→8→1, declares lock after a configurable run of correct steps, and counts sequence errors once locked. Sits beside the display driver in the top level; its status outputs are routed to LEDs and to the LCD debug fields.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_ring_monitor_if.sv | 29 ++
 rtl/seg7_decode.sv | 42 ++++
 rtl/seg_ring_monitor.sv | 139 +++++++++++++
 tb/tb_seg_ring_monitor.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment constants, monitor state encoding and ring successor helper
// Contents:
//   SEG_0..SEG_F : gfedcba patterns for the hex digits (bit 7 / decimal point excluded)
//   mon_state_t  : monitor FSM state codes (HUNT=0, TRACK=1, LOCKED=2; 3 unused)
//   ring_next    : successor on the 1->2->4->8->1 ring
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // Non-ring inputs map to 1 so a stray value can never leave the ring.
    function automatic logic [3:0] ring_next(input logic [3:0] d);
        return d == 4'd1 ? 4'd2 : d == 4'd2 ? 4'd4 : d == 4'd4 ? 4'd8 : 4'd1;
    endfunction

endpackage

// File: rtl/seg_ring_monitor_if.sv
// seg_ring_monitor_if: sample bus and status bundle between a display driver tap and the ring monitor
// Signals:
//   sample_en, seg_in                  : driver -> monitor (sample strobe, segment pattern)
//   digit, digit_valid, locked,
//   err_pulse, err_count, state        : monitor -> consumers (LEDs, LCD debug)
// Modports: master (drives the samples, reads status), slave (the monitor)
interface seg_ring_monitor_if #(
    parameter int NBITS_SEG = 8,
    parameter int ERR_W     = 8
);
    logic                 sample_en;
    logic [NBITS_SEG-1:0] seg_in;
    logic [3:0]           digit;
    logic                 digit_valid;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_W-1:0]     err_count;
    logic [1:0]           state;

    modport master (
        output sample_en, seg_in,
        input  digit, digit_valid, locked, err_pulse, err_count, state
    );

    modport slave (
        input  sample_en, seg_in,
        output digit, digit_valid, locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational seven-segment pattern to digit decoder
// Ports:
//   i_seg   : gfedcba pattern (decimal point already stripped)
//   o_digit : decoded value, 0 when unrecognised
//   o_valid : pattern recognised
// Build option: SEG_MON_HEX_EN adds the remaining hex glyphs 3,5,6,7,9,A-F;
// without it only the ring glyphs 1,2,4,8 and the blank-reset glyph 0 decode.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_valid
);

    always_comb begin
        o_digit = 4'd0;
        o_valid = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'h0;
            SEG_1:   o_digit = 4'h1;
            SEG_2:   o_digit = 4'h2;
            SEG_4:   o_digit = 4'h4;
            SEG_8:   o_digit = 4'h8;
`ifdef SEG_MON_HEX_EN
            SEG_3:   o_digit = 4'h3;
            SEG_5:   o_digit = 4'h5;
            SEG_6:   o_digit = 4'h6;
            SEG_7:   o_digit = 4'h7;
            SEG_9:   o_digit = 4'h9;
            SEG_A:   o_digit = 4'hA;
            SEG_B:   o_digit = 4'hB;
            SEG_C:   o_digit = 4'hC;
            SEG_D:   o_digit = 4'hD;
            SEG_E:   o_digit = 4'hE;
            SEG_F:   o_digit = 4'hF;
`endif
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_ring_monitor.sv
// seg_ring_monitor: receive-side checker for the one-hot seven-segment ring display
// Ports:
//   clk_2 : clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg_ring_monitor_if.slave (sample_en/seg_in in; digit, digit_valid,
//           locked, err_pulse, err_count, state out; all outputs registered)
// Parameters: LOCK_COUNT (>= 2) correct ring steps to lock, ERR_W error counter width.
// Build option: SEG_MON_HEX_EN (inside seg7_decode) only widens digit decoding;
// the FSM treats every non-ring, non-zero glyph as invalid in both builds.
module seg_ring_monitor
    import seg_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic                clk_2,
    input  logic                reset,
    seg_ring_monitor_if.slave   bus
);

    localparam int RW = $clog2(LOCK_COUNT + 1);

    mon_state_t       r_state;
    logic [RW-1:0]    r_run;
    logic [3:0]       r_expected;
    logic [3:0]       r_digit;
    logic             r_digit_valid;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    mon_state_t       w_state_nx;
    logic [RW-1:0]    w_run_nx;
    logic [RW-1:0]    w_run_inc;
    logic [3:0]       w_expected_nx;
    logic [3:0]       w_dec_digit;
    logic             w_dec_valid;
    logic             w_ring;
    logic             w_match;
    logic             w_zero;
    logic             w_err;

    seg7_decode u_dec (
        .i_seg   (bus.seg_in[6:0]),
        .o_digit (w_dec_digit),
        .o_valid (w_dec_valid)
    );

    // Hex glyphs are valid decodes but never ring digits, so they fall through as invalid.
    assign w_ring    = w_dec_valid && (w_dec_digit == 4'd1 || w_dec_digit == 4'd2 ||
                                       w_dec_digit == 4'd4 || w_dec_digit == 4'd8);
    assign w_match   = w_dec_valid && w_dec_digit == r_expected;
    assign w_zero    = w_dec_valid && w_dec_digit == 4'd0;
    assign w_run_inc = r_run + RW'(1);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state       <= HUNT;
            r_run         <= '0;
            r_expected    <= 4'd1;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_run       <= w_run_nx;
            r_expected  <= w_expected_nx;
            r_err_pulse <= w_err;
            if (bus.sample_en) begin
                r_digit_valid <= w_dec_valid;
                if (w_dec_valid)
                    r_digit <= w_dec_digit;
            end
            if (w_err && r_err_count != '1)
                r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_run_nx      = r_run;
        w_expected_nx = r_expected;
        case (r_state)
            HUNT: begin
                if (bus.sample_en && w_ring) begin
                    w_state_nx    = TRACK;
                    w_run_nx      = RW'(1);
                    w_expected_nx = ring_next(w_dec_digit);
                end
            end
            TRACK: begin
                if (bus.sample_en) begin
                    if (w_match) begin
                        w_run_nx      = w_run_inc;
                        w_expected_nx = ring_next(w_dec_digit);
                        if (w_run_inc == RW'(LOCK_COUNT))
                            w_state_nx = LOCKED;
                    end else if (w_ring) begin
                        w_run_nx      = RW'(1);
                        w_expected_nx = ring_next(w_dec_digit);
                    end else begin
                        w_state_nx    = HUNT;
                        w_run_nx      = '0;
                        w_expected_nx = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (bus.sample_en) begin
                    if (w_match) begin
                        w_expected_nx = ring_next(w_dec_digit);
                    end else begin
                        w_state_nx    = HUNT;
                        w_run_nx      = '0;
                        w_expected_nx = 4'd1;
                    end
                end
            end
            default: begin
                w_state_nx    = HUNT;
                w_run_nx      = '0;
                w_expected_nx = 4'd1;
            end
        endcase
    end

    // A blank (0) while locked is the driver restarting, not a sequence error.
    always_comb begin
        w_err = bus.sample_en && r_state == LOCKED && !w_match && !w_zero;
    end

    assign bus.digit       = r_digit;
    assign bus.digit_valid = r_digit_valid;
    assign bus.locked      = r_state == LOCKED;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_count   = r_err_count;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_seg_ring_monitor.sv
// tb_seg_ring_monitor: directed self-checking bench for seg_ring_monitor
// dut_a uses default sizing (ERR_W=8); dut_b uses ERR_W=2 for the saturation scenario.
module tb_seg_ring_monitor;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_2 = ~clk_2;

    seg_ring_monitor_if #(.NBITS_SEG(8), .ERR_W(8)) bus_a ();
    seg_ring_monitor_if #(.NBITS_SEG(8), .ERR_W(2)) bus_b ();

    seg_ring_monitor #(.LOCK_COUNT(4), .ERR_W(8)) dut_a (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_a)
    );

    seg_ring_monitor #(.LOCK_COUNT(4), .ERR_W(2)) dut_b (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic idle();
        bus_a.sample_en = 1'b0;
        bus_b.sample_en = 1'b0;
        @(posedge clk_2);
        #1;
    endtask

    task automatic sample_a(input logic [7:0] seg);
        bus_a.sample_en = 1'b1;
        bus_a.seg_in    = seg;
        bus_b.sample_en = 1'b0;
        @(posedge clk_2);
        #1;
        bus_a.sample_en = 1'b0;
    endtask

    task automatic sample_b(input logic [7:0] seg);
        bus_b.sample_en = 1'b1;
        bus_b.seg_in    = seg;
        bus_a.sample_en = 1'b0;
        @(posedge clk_2);
        #1;
        bus_b.sample_en = 1'b0;
    endtask

    task automatic lock_a();
        sample_a(8'h06);
        sample_a(8'h5B);
        sample_a(8'h66);
        sample_a(8'h7F);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        idle();
        n_checks++;
        if ({bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count} !== 17'd0) begin
            $display("FAIL reset_a: got state=%0d digit=%0d valid=%0b locked=%0b pulse=%0b count=%0d, want all 0",
                     bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count);
            n_fail++;
        end
        n_checks++;
        if ({bus_b.state, bus_b.locked, bus_b.err_count} !== 5'd0) begin
            $display("FAIL reset_b: got state=%0d locked=%0b count=%0d, want 0", bus_b.state, bus_b.locked, bus_b.err_count);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        sample_a(8'h06);
        n_checks++;
        if (bus_a.state !== 2'd1 || bus_a.digit !== 4'd1 || bus_a.digit_valid !== 1'b1) begin
            $display("FAIL lock_first: got state=%0d digit=%0d valid=%0b, want 1/1/1", bus_a.state, bus_a.digit, bus_a.digit_valid);
            n_fail++;
        end
        sample_a(8'h5B);
        sample_a(8'h66);
        n_checks++;
        if (bus_a.state !== 2'd1 || bus_a.locked !== 1'b0) begin
            $display("FAIL lock_third: got state=%0d locked=%0b, want 1/0", bus_a.state, bus_a.locked);
            n_fail++;
        end
        sample_a(8'h7F);
        n_checks++;
        if (bus_a.locked !== 1'b1 || bus_a.digit !== 4'd8 || bus_a.state !== 2'd2 || bus_a.err_count !== 8'd0) begin
            $display("FAIL lock_done: got locked=%0b digit=%0d state=%0d count=%0d, want 1/8/2/0",
                     bus_a.locked, bus_a.digit, bus_a.state, bus_a.err_count);
            n_fail++;
        end
    endtask

    task automatic test_skip_error();
        sample_a(8'h06);
        n_checks++;
        if (bus_a.state !== 2'd2 || bus_a.digit !== 4'd1 || bus_a.err_pulse !== 1'b0) begin
            $display("FAIL skip_wrap: got state=%0d digit=%0d pulse=%0b, want 2/1/0", bus_a.state, bus_a.digit, bus_a.err_pulse);
            n_fail++;
        end
        sample_a(8'h66);
        n_checks++;
        if (bus_a.err_pulse !== 1'b1 || bus_a.err_count !== 8'd1 || bus_a.state !== 2'd0 ||
            bus_a.locked !== 1'b0 || bus_a.digit !== 4'd4) begin
            $display("FAIL skip_err: got pulse=%0b count=%0d state=%0d locked=%0b digit=%0d, want 1/1/0/0/4",
                     bus_a.err_pulse, bus_a.err_count, bus_a.state, bus_a.locked, bus_a.digit);
            n_fail++;
        end
        idle();
        n_checks++;
        if (bus_a.err_pulse !== 1'b0 || bus_a.err_count !== 8'd1) begin
            $display("FAIL skip_pulse_width: got pulse=%0b count=%0d, want 0/1", bus_a.err_pulse, bus_a.err_count);
            n_fail++;
        end
    endtask

    task automatic test_driver_reset();
        lock_a();
        sample_a(8'h3F);
        n_checks++;
        if (bus_a.state !== 2'd0 || bus_a.digit !== 4'd0 || bus_a.digit_valid !== 1'b1 ||
            bus_a.err_count !== 8'd1 || bus_a.err_pulse !== 1'b0) begin
            $display("FAIL driver_reset: got state=%0d digit=%0d valid=%0b count=%0d pulse=%0b, want 0/0/1/1/0",
                     bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.err_count, bus_a.err_pulse);
            n_fail++;
        end
    endtask

    task automatic test_strobe_gating();
        lock_a();
        for (int i = 0; i < 10; i++) begin
            bus_a.seg_in = 8'($urandom);
            idle();
            n_checks++;
            if ({bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count} !==
                {2'd2, 4'd8, 1'b1, 1'b1, 1'b0, 8'd1}) begin
                $display("FAIL gating_%0d: got state=%0d digit=%0d valid=%0b locked=%0b pulse=%0b count=%0d, want 2/8/1/1/0/1",
                         i, bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count);
                n_fail++;
            end
        end
    endtask

    task automatic test_track_restart();
        sample_a(8'h3F);
        sample_a(8'h06);
        sample_a(8'h5B);
        sample_a(8'h7F);
        n_checks++;
        if (bus_a.state !== 2'd1 || bus_a.err_pulse !== 1'b0 || bus_a.digit !== 4'd8) begin
            $display("FAIL restart_skip: got state=%0d pulse=%0b digit=%0d, want 1/0/8", bus_a.state, bus_a.err_pulse, bus_a.digit);
            n_fail++;
        end
        sample_a(8'h06);
        sample_a(8'h5B);
        n_checks++;
        if (bus_a.state !== 2'd1) begin
            $display("FAIL restart_run3: got state=%0d, want 1", bus_a.state);
            n_fail++;
        end
        sample_a(8'h66);
        n_checks++;
        if (bus_a.state !== 2'd2 || bus_a.err_count !== 8'd1) begin
            $display("FAIL restart_lock: got state=%0d count=%0d, want 2/1", bus_a.state, bus_a.err_count);
            n_fail++;
        end
        sample_a(8'h7F);
        sample_a(8'h80);
        n_checks++;
        if (bus_a.err_pulse !== 1'b1 || bus_a.err_count !== 8'd2 || bus_a.digit !== 4'd8 || bus_a.digit_valid !== 1'b0) begin
            $display("FAIL invalid_locked: got pulse=%0b count=%0d digit=%0d valid=%0b, want 1/2/8/0",
                     bus_a.err_pulse, bus_a.err_count, bus_a.digit, bus_a.digit_valid);
            n_fail++;
        end
    endtask

    task automatic test_hex_decode();
        logic [3:0] exp_digit;
        logic       exp_valid;
`ifdef SEG_MON_HEX_EN
        exp_digit = 4'd3;
        exp_valid = 1'b1;
`else
        exp_digit = 4'd1;
        exp_valid = 1'b0;
`endif
        sample_a(8'h06);
        sample_a(8'h4F);
        n_checks++;
        if (bus_a.digit !== exp_digit || bus_a.digit_valid !== exp_valid || bus_a.state !== 2'd0 ||
            bus_a.err_pulse !== 1'b0 || bus_a.err_count !== 8'd2) begin
            $display("FAIL hex_track: got digit=%0d valid=%0b state=%0d pulse=%0b count=%0d, want %0d/%0b/0/0/2",
                     bus_a.digit, bus_a.digit_valid, bus_a.state, bus_a.err_pulse, bus_a.err_count, exp_digit, exp_valid);
            n_fail++;
        end
        lock_a();
        bus_a.sample_en = 1'b1;
        bus_a.seg_in    = 8'h06;
        reset = 1'b1;
        @(posedge clk_2);
        #1;
        bus_a.sample_en = 1'b0;
        reset = 1'b0;
        n_checks++;
        if ({bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count} !== 17'd0) begin
            $display("FAIL reset_locked: got state=%0d digit=%0d valid=%0b locked=%0b pulse=%0b count=%0d, want all 0",
                     bus_a.state, bus_a.digit, bus_a.digit_valid, bus_a.locked, bus_a.err_pulse, bus_a.err_count);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_count;
        for (int r = 1; r <= 4; r++) begin
            sample_b(8'h06);
            sample_b(8'h5B);
            sample_b(8'h66);
            sample_b(8'h7F);
            sample_b(8'h5B);
            exp_count = r >= 3 ? 2'd3 : 2'(r);
            n_checks++;
            if (bus_b.err_pulse !== 1'b1 || bus_b.err_count !== exp_count || bus_b.state !== 2'd0) begin
                $display("FAIL sat_round_%0d: got pulse=%0b count=%0d state=%0d, want 1/%0d/0",
                         r, bus_b.err_pulse, bus_b.err_count, bus_b.state, exp_count);
                n_fail++;
            end
        end
    endtask

    initial begin
        bus_a.sample_en = 1'b0;
        bus_a.seg_in    = 8'h00;
        bus_b.sample_en = 1'b0;
        bus_b.seg_in    = 8'h00;
        test_reset();
        test_lock();
        test_skip_error();
        test_driver_reset();
        test_strobe_gating();
        test_track_restart();
        test_hex_decode();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
